// File: rtl/pkg_tpu.sv
// Shared TPU types and constants for the data-memory access path.
package pkg_tpu;

  typedef logic [15:0] data_t;
  typedef logic [31:0] address_t;
  typedef logic [15:0] stride_t;

  localparam int NUM_DMEM_REQ = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RUN   = 2'd3
  } fsm_arb_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner search: first set request bit at or above start, with wrap.
module rr_select #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [PTR_W-1:0] pos_s;

  // Scan N positions upward from start; the first hit wins and later hits are ignored.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos_s = '0;
    for (int k = 0; k < N; k++) begin
      pos_s = PTR_W'((int'(start) + k) % N);
      if (!valid && req[pos_s]) begin
        valid = 1'b1;
        idx   = pos_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares one data-memory access unit among NUM_REQ requesters with
// round-robin arbitration, per-requester configuration capture and abort.
module dmem_access_arbiter
  import pkg_tpu::*;
#(
  parameter int NUM_REQ = NUM_DMEM_REQ
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic     [NUM_REQ-1:0]   I_Req,
  input  logic     [NUM_REQ-1:0]   I_St,
  input  address_t [NUM_REQ-1:0]   I_Length,
  input  stride_t  [NUM_REQ-1:0]   I_Stride,
  input  address_t [NUM_REQ-1:0]   I_Base,
  input  logic     [NUM_REQ-1:0]   I_Rls,
  input  data_t    [NUM_REQ-1:0]   I_St_Data,
  output logic     [NUM_REQ-1:0]   O_Grant,
  output logic     [NUM_REQ-1:0]   O_Term,
  output logic     [NUM_REQ-1:0]   O_Ld_Valid,
  output data_t                    O_Ld_Data,
  output logic                     O_Mem_Req,
  output logic                     O_Mem_St,
  output address_t                 O_Mem_Length,
  output stride_t                  O_Mem_Stride,
  output address_t                 O_Mem_Base,
  output data_t                    O_Mem_St_Data,
  output logic                     O_Mem_Abort,
  input  logic                     I_Mem_Grant,
  input  logic                     I_Mem_Term,
  input  data_t                    I_Mem_Ld_Data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  fsm_arb_t                 state_r, state_s;
  logic     [NUM_REQ-1:0]   pend_r;
  logic     [PTR_W-1:0]     owner_r, rr_ptr_r, sel_idx_s, next_ptr_s;
  logic                     sel_vld_s, access_end_s;
  logic     [NUM_REQ-1:0]   owner_oh_s, owner_act_s;
  logic     [NUM_REQ-1:0]   st_cfg_r;
  address_t [NUM_REQ-1:0]   len_cfg_r, base_cfg_r;
  stride_t  [NUM_REQ-1:0]   stride_cfg_r;

  // Only registered Pend takes part in a decision, so a request arriving
  // in the decision cycle waits for the next round.
  rr_select #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_select (
    .req   (pend_r),
    .start (rr_ptr_r),
    .idx   (sel_idx_s),
    .valid (sel_vld_s)
  );

  assign next_ptr_s = (owner_r == LAST_IDX) ? '0 : owner_r + PTR_W'(1);

  // Decode the owner index; the owner only counts as active outside ARB_IDLE.
  always_comb begin
    owner_oh_s  = '0;
    owner_act_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh_s[i]  = (owner_r == PTR_W'(i));
      owner_act_s[i] = owner_oh_s[i] && (state_r != ARB_IDLE);
    end
  end

  // Next state and all outputs; abort by the owner beats grant and term.
  always_comb begin
    state_s       = state_r;
    access_end_s  = 1'b0;
    O_Grant       = '0;
    O_Term        = '0;
    O_Ld_Valid    = '0;
    O_Ld_Data     = '0;
    O_Mem_Req     = 1'b0;
    O_Mem_St      = 1'b0;
    O_Mem_Length  = '0;
    O_Mem_Stride  = '0;
    O_Mem_Base    = '0;
    O_Mem_St_Data = '0;
    O_Mem_Abort   = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (sel_vld_s) begin
          state_s = ARB_ISSUE;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        O_Mem_Req    = 1'b1;
        O_Mem_St     = st_cfg_r[owner_r];
        O_Mem_Length = len_cfg_r[owner_r];
        O_Mem_Stride = stride_cfg_r[owner_r];
        O_Mem_Base   = base_cfg_r[owner_r];
        state_s      = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (I_Rls[owner_r]) begin
          O_Mem_Abort  = 1'b1;
          access_end_s = 1'b1;
          state_s      = ARB_IDLE;
        end else if (I_Mem_Grant) begin
          O_Grant = owner_oh_s;
          if (I_Mem_Term) begin
            // A zero-length access still ends the owner's turn.
            O_Term       = owner_oh_s;
            access_end_s = 1'b1;
            state_s      = ARB_IDLE;
          end else begin
            state_s = ARB_RUN;
          end
        end else begin
          state_s = ARB_WAIT;
        end
      end
      ARB_RUN: begin
        if (st_cfg_r[owner_r]) begin
          O_Mem_St_Data = I_St_Data[owner_r];
        end else begin
          O_Ld_Data  = I_Mem_Ld_Data;
          O_Ld_Valid = owner_oh_s;
        end
        if (I_Rls[owner_r]) begin
          O_Mem_Abort  = 1'b1;
          access_end_s = 1'b1;
          state_s      = ARB_IDLE;
        end else if (I_Mem_Term) begin
          O_Term       = owner_oh_s;
          access_end_s = 1'b1;
          state_s      = ARB_IDLE;
        end else begin
          state_s = ARB_RUN;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // FSM state, owner latch at decision time, and pointer advance at access end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ARB_IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == ARB_IDLE) && sel_vld_s) begin
        owner_r <= sel_idx_s;
      end
      if (access_end_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

  // Per-requester pending flag and configuration capture; duplicates are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_r       <= '0;
      st_cfg_r     <= '0;
      len_cfg_r    <= '0;
      stride_cfg_r <= '0;
      base_cfg_r   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend_r[i] && !owner_act_s[i] && I_Rls[i]) begin
          pend_r[i] <= 1'b0;
        end else if (!pend_r[i] && !owner_act_s[i] && I_Req[i]) begin
          pend_r[i]       <= 1'b1;
          st_cfg_r[i]     <= I_St[i];
          len_cfg_r[i]    <= I_Length[i];
          stride_cfg_r[i] <= I_Stride[i];
          base_cfg_r[i]   <= I_Base[i];
        end else if ((state_r == ARB_ISSUE) && owner_oh_s[i]) begin
          pend_r[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter: directed scenarios plus random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_dmem_access_arbiter;
  import pkg_tpu::*;

  localparam int N = 4;

  logic clock, reset;
  logic     [N-1:0] req_s, st_s, rls_s;
  address_t [N-1:0] len_s, base_s;
  stride_t  [N-1:0] stride_s;
  data_t    [N-1:0] st_data_s;
  logic             mem_grant_s, mem_term_s;
  data_t            mem_ld_data_s;

  logic [N-1:0] grant_o, term_o, ld_valid_o;
  data_t        ld_data_o, mem_st_data_o;
  logic         mem_req_o, mem_st_o, mem_abort_o;
  address_t     mem_len_o, mem_base_o;
  stride_t      mem_stride_o;

  int n_cmp, n_err;

  dmem_access_arbiter #(.NUM_REQ(N)) dut (
    .clock(clock), .reset(reset),
    .I_Req(req_s), .I_St(st_s), .I_Length(len_s), .I_Stride(stride_s), .I_Base(base_s),
    .I_Rls(rls_s), .I_St_Data(st_data_s),
    .O_Grant(grant_o), .O_Term(term_o), .O_Ld_Valid(ld_valid_o), .O_Ld_Data(ld_data_o),
    .O_Mem_Req(mem_req_o), .O_Mem_St(mem_st_o), .O_Mem_Length(mem_len_o),
    .O_Mem_Stride(mem_stride_o), .O_Mem_Base(mem_base_o), .O_Mem_St_Data(mem_st_data_o),
    .O_Mem_Abort(mem_abort_o),
    .I_Mem_Grant(mem_grant_s), .I_Mem_Term(mem_term_s), .I_Mem_Ld_Data(mem_ld_data_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // owner = -1 means no access in progress; an access is issued, then granted.
  logic     [N-1:0] m_pend, m_st;
  address_t [N-1:0] m_len, m_base;
  stride_t  [N-1:0] m_stride;
  int m_owner, m_ptr;
  bit m_issued, m_granted;

  task automatic model_clear();
    m_pend = '0; m_st = '0; m_len = '0; m_base = '0; m_stride = '0;
    m_owner = -1; m_ptr = 0; m_issued = 1'b0; m_granted = 1'b0;
  endtask

  // Predict and compare every output mid-cycle, then advance the model.
  always @(negedge clock) begin : ref_model
    logic [N-1:0] e_grant, e_term, e_ldv, old_pend;
    logic         e_req, e_st, e_abort;
    address_t     e_len, e_base;
    stride_t      e_stride;
    data_t        e_std, e_ldd;
    bit           fin;
    if (!reset) model_clear();
    e_grant = '0; e_term = '0; e_ldv = '0; e_req = 1'b0; e_st = 1'b0; e_abort = 1'b0;
    e_len = '0; e_base = '0; e_stride = '0; e_std = '0; e_ldd = '0;
    if (m_owner >= 0 && !m_issued) begin
      e_req = 1'b1; e_st = m_st[m_owner]; e_len = m_len[m_owner];
      e_base = m_base[m_owner]; e_stride = m_stride[m_owner];
    end else if (m_owner >= 0 && !m_granted) begin
      if (rls_s[m_owner]) e_abort = 1'b1;
      else if (mem_grant_s) begin
        e_grant[m_owner] = 1'b1;
        e_term[m_owner]  = mem_term_s;
      end
    end else if (m_owner >= 0) begin
      if (m_st[m_owner]) e_std = st_data_s[m_owner];
      else begin
        e_ldd = mem_ld_data_s;
        e_ldv[m_owner] = 1'b1;
      end
      if (rls_s[m_owner]) e_abort = 1'b1;
      else e_term[m_owner] = mem_term_s;
    end
    check_eq("m_grant", grant_o, e_grant);
    check_eq("m_term", term_o, e_term);
    check_eq("m_ld_valid", ld_valid_o, e_ldv);
    check_eq("m_ld_data", ld_data_o, e_ldd);
    check_eq("m_mem_req", mem_req_o, e_req);
    check_eq("m_mem_st", mem_st_o, e_st);
    check_eq("m_mem_len", mem_len_o, e_len);
    check_eq("m_mem_stride", mem_stride_o, e_stride);
    check_eq("m_mem_base", mem_base_o, e_base);
    check_eq("m_mem_st_data", mem_st_data_o, e_std);
    check_eq("m_mem_abort", mem_abort_o, e_abort);
    if (reset) begin
      old_pend = m_pend;
      for (int i = 0; i < N; i++) begin
        if (m_owner != i) begin
          if (old_pend[i] && rls_s[i]) m_pend[i] = 1'b0;
          else if (!old_pend[i] && req_s[i]) begin
            m_pend[i] = 1'b1; m_st[i] = st_s[i]; m_len[i] = len_s[i];
            m_stride[i] = stride_s[i]; m_base[i] = base_s[i];
          end
        end
      end
      fin = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && old_pend[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N; m_issued = 1'b0; m_granted = 1'b0;
          end
        end
      end else if (!m_issued) begin
        m_issued = 1'b1;
        m_pend[m_owner] = 1'b0;
      end else if (!m_granted) begin
        if (rls_s[m_owner]) fin = 1'b1;
        else if (mem_grant_s) begin
          if (mem_term_s) fin = 1'b1;
          else m_granted = 1'b1;
        end
      end else begin
        fin = rls_s[m_owner] || mem_term_s;
      end
      if (fin) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_s = '0; st_s = '0; rls_s = '0; len_s = '0; base_s = '0; stride_s = '0;
    st_data_s = '0; mem_grant_s = 1'b0; mem_term_s = 1'b0; mem_ld_data_s = '0;
  endtask

  task automatic drive_req(input int i, input logic st, input address_t len,
                           input stride_t str, input address_t base);
    req_s[i] = 1'b1; st_s[i] = st; len_s[i] = len; stride_s[i] = str; base_s[i] = base;
  endtask

  // Called at posedge+1; returns at posedge+2 of the issue cycle (or after the budget).
  task automatic wait_issue(input string tag);
    int k;
    k = 0;
    #1;
    while (mem_req_o !== 1'b1 && k < 20) begin
      step();
      #1;
      k++;
    end
    check_eq(tag, mem_req_o, 1'b1);
  endtask

  task automatic serve(input int who, input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[who] = 1'b1;
    wait_issue(tag);
    step(); mem_grant_s = 1'b1; #1 check_eq({tag, "_grant"}, grant_o, oh);
    step(); mem_grant_s = 1'b0; mem_term_s = 1'b1; #1 check_eq({tag, "_term"}, term_o, oh);
    step(); mem_term_s = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    model_clear();
    idle_inputs();
    reset = 1'b0;
    #2;
    check_eq("rst_mem_req", mem_req_o, 1'b0);
    check_eq("rst_grant", grant_o, 4'b0000);
    check_eq("rst_term", term_o, 4'b0000);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Fairness: four simultaneous requests served 0,1,2,3; 0 re-requests and follows 3.
    for (int i = 0; i < N; i++) drive_req(i, 1'b0, 32'd8, 16'd1, 32'h1000 + 32'(i * 16));
    step(); req_s = '0;
    serve(0, "fair_0");
    drive_req(0, 1'b0, 32'd4, 16'd2, 32'h2000);
    step(); req_s = '0;
    serve(1, "fair_1");
    serve(2, "fair_2");
    serve(3, "fair_3");
    serve(0, "fair_0_again");

    // Single load on requester 2 with the latency and data path checked.
    drive_req(2, 1'b0, 32'd16, 16'd1, 32'h100);
    step(); req_s = '0;
    #1 check_eq("lat_t1_no_req", mem_req_o, 1'b0);
    step(); #1;
    check_eq("lat_t2_req", mem_req_o, 1'b1);
    check_eq("ld_len", mem_len_o, 32'd16);
    check_eq("ld_stride", mem_stride_o, 16'd1);
    check_eq("ld_base", mem_base_o, 32'h100);
    check_eq("ld_st", mem_st_o, 1'b0);
    step(); mem_grant_s = 1'b1; #1 check_eq("ld_grant", grant_o, 4'b0100);
    step(); mem_grant_s = 1'b0; mem_ld_data_s = 16'h00A5;
    #1 check_eq("ld_data", ld_data_o, 16'h00A5);
    check_eq("ld_valid", ld_valid_o, 4'b0100);
    step(); mem_term_s = 1'b1; #1 check_eq("ld_term", term_o, 4'b0100);
    step(); mem_term_s = 1'b0; mem_ld_data_s = '0;

    // Store from requester 1: only its own data reaches memory.
    drive_req(1, 1'b1, 32'd8, 16'd2, 32'h300);
    step(); req_s = '0;
    wait_issue("st_issue");
    step(); mem_grant_s = 1'b1;
    step(); mem_grant_s = 1'b0;
    st_data_s[1] = 16'h55AA; st_data_s[0] = 16'hFFFF; mem_ld_data_s = 16'h1234;
    #1 check_eq("st_data", mem_st_data_o, 16'h55AA);
    check_eq("st_ld_valid", ld_valid_o, 4'b0000);
    check_eq("st_ld_data", ld_data_o, 16'h0000);
    step(); mem_term_s = 1'b1;
    step(); mem_term_s = 1'b0; st_data_s = '0; mem_ld_data_s = '0;

    // Abort by owner 3 beats term; pending 0 keeps its first Base despite a duplicate.
    drive_req(3, 1'b0, 32'd4, 16'd1, 32'h400);
    drive_req(0, 1'b0, 32'd16, 16'd1, 32'h100);
    step(); req_s = '0;
    wait_issue("ab_issue");
    check_eq("ab_issue_base", mem_base_o, 32'h400);
    step();
    drive_req(0, 1'b0, 32'd16, 16'd1, 32'h200);
    mem_grant_s = 1'b1;
    step(); req_s = '0; mem_grant_s = 1'b0;
    rls_s[3] = 1'b1; mem_term_s = 1'b1;
    #1 check_eq("ab_abort", mem_abort_o, 1'b1);
    check_eq("ab_no_term", term_o, 4'b0000);
    step(); rls_s = '0; mem_term_s = 1'b0;
    #1 check_eq("ab_gap", mem_req_o, 1'b0);
    step(); #1 check_eq("ab_next_req", mem_req_o, 1'b1);
    check_eq("dup_base", mem_base_o, 32'h100);
    step(); mem_grant_s = 1'b1; mem_term_s = 1'b1;
    #1 check_eq("gt_grant", grant_o, 4'b0001);
    check_eq("gt_term", term_o, 4'b0001);
    step(); mem_grant_s = 1'b0; mem_term_s = 1'b0;
    #1 check_eq("gt_idle", mem_req_o, 1'b0);

    // Asynchronous reset in the middle of a load.
    drive_req(2, 1'b0, 32'd2, 16'd1, 32'h500);
    step(); req_s = '0;
    wait_issue("rst_issue");
    step(); mem_grant_s = 1'b1;
    step(); mem_grant_s = 1'b0; mem_ld_data_s = 16'h0077;
    #1 check_eq("rst_pre_valid", ld_valid_o, 4'b0100);
    reset = 1'b0;
    #1;
    check_eq("rst_async_valid", ld_valid_o, 4'b0000);
    check_eq("rst_async_data", ld_data_o, 16'h0000);
    check_eq("rst_async_grant", grant_o, 4'b0000);
    mem_term_s = 1'b1; rls_s = 4'b0100;
    #1 check_eq("rst_no_term", term_o, 4'b0000);
    check_eq("rst_no_abort", mem_abort_o, 1'b0);
    step(); mem_term_s = 1'b0; rls_s = '0; mem_ld_data_s = '0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      #1 check_eq("post_rst_idle", mem_req_o, 1'b0);
    end

    // Random traffic, checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      req_s = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rls_s = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      st_s = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        len_s[i]     = 32'($urandom);
        base_s[i]    = 32'($urandom);
        stride_s[i]  = 16'($urandom);
        st_data_s[i] = 16'($urandom);
      end
      mem_grant_s   = 1'($urandom_range(0, 1));
      mem_term_s    = ($urandom_range(0, 2) == 0);
      mem_ld_data_s = 16'($urandom);
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
